mips_multicycle_ctrl: RTL

Multicycle MIPS control unit. It is the producer side of the 4-bit alu_control interface. It sequences each instruction through a Moore FSM and drives the datapath mux selects, write enables and alu_control. It decodes op/funct from the instruction register and takes the ALU zero flag back for branch resolution.

---
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_multicycle_ctrl_if                                      |
// | Description : Control bus between the multicycle MIPS controller (master)  |
// |               and the datapath (slave): decode inputs and control outputs. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [3:0] alu_control;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_multicycle_ctrl                                         |
// | Description : Moore-FSM control unit for a multicycle MIPS datapath.       |
// |               Optional macro MIPS_CTRL_BNE_EN adds bne support.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl (
    input  wire logic              clk,
    input  wire logic              reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_RTYP = 6'b000000;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    state_t     r_state;
    state_t     w_next;
    logic       r_iord;
    logic       r_mem_write;
    logic       r_ir_write;
    logic       r_reg_dst;
    logic       r_mem_to_reg;
    logic       r_reg_write;
    logic       r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [1:0] r_pc_src;
    logic       r_pc_en;
    logic [3:0] r_alu_control;
    logic [3:0] w_funct_alu;
    logic       w_take;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYP:        w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    6'b000101:        w_next = S_BRANCH;
`endif
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_funct_alu = 4'b1111;
        case (bus.funct)
            6'b100000: w_funct_alu = 4'b0010;
            6'b100010: w_funct_alu = 4'b0110;
            6'b100100: w_funct_alu = 4'b0000;
            6'b100101: w_funct_alu = 4'b0001;
            6'b101010: w_funct_alu = 4'b0111;
            default:   w_funct_alu = 4'b1111;
        endcase
    end

`ifdef MIPS_CTRL_BNE_EN
    logic r_bne;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bne <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_bne <= (bus.op == 6'b000101);
        end
    end
    assign w_take = r_bne ? ~bus.zero : bus.zero;
`else
    assign w_take = bus.zero;
`endif

    // Outputs are registered for the state being entered, so they are valid from its first cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_iord        <= 1'b0;
            r_mem_write   <= 1'b0;
            r_ir_write    <= 1'b1;
            r_reg_dst     <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            r_alu_src_a   <= 1'b0;
            r_alu_src_b   <= 2'b01;
            r_pc_src      <= 2'b00;
            r_pc_en       <= 1'b1;
            r_alu_control <= c_ALU_ADD;
        end else begin
            r_state       <= w_next;
            r_iord        <= 1'b0;
            r_mem_write   <= 1'b0;
            r_ir_write    <= 1'b0;
            r_reg_dst     <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            r_alu_src_a   <= 1'b0;
            r_alu_src_b   <= 2'b00;
            r_pc_src      <= 2'b00;
            r_pc_en       <= 1'b0;
            r_alu_control <= c_ALU_ADD;
            case (w_next)
                S_FETCH: begin
                    r_alu_src_b <= 2'b01;
                    r_ir_write  <= 1'b1;
                    r_pc_en     <= 1'b1;
                end
                S_DECODE:  r_alu_src_b <= 2'b11;
                S_MEMADR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                end
                S_MEMRD:   r_iord <= 1'b1;
                S_MEMWB: begin
                    r_mem_to_reg <= 1'b1;
                    r_reg_write  <= 1'b1;
                end
                S_MEMWR: begin
                    r_iord      <= 1'b1;
                    r_mem_write <= 1'b1;
                end
                S_EXECUTE: r_alu_src_a <= 1'b1;
                S_ALUWB: begin
                    r_reg_dst   <= 1'b1;
                    r_reg_write <= 1'b1;
                end
                S_BRANCH: begin
                    r_alu_src_a   <= 1'b1;
                    r_alu_control <= c_ALU_SUB;
                    r_pc_src      <= 2'b01;
                end
                S_ADDIEX: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                end
                S_ADDIWB:  r_reg_write <= 1'b1;
                S_JUMP: begin
                    r_pc_src <= 2'b10;
                    r_pc_en  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write enables are gated by reset so an abort can never leak a pulse.
    assign bus.iord        = r_iord;
    assign bus.mem_write   = r_mem_write & ~reset;
    assign bus.ir_write    = r_ir_write & ~reset;
    assign bus.reg_dst     = r_reg_dst;
    assign bus.mem_to_reg  = r_mem_to_reg;
    assign bus.reg_write   = r_reg_write & ~reset;
    assign bus.alu_src_a   = r_alu_src_a;
    assign bus.alu_src_b   = r_alu_src_b;
    assign bus.pc_src      = r_pc_src;
    assign bus.pc_en       = (r_pc_en | ((r_state == S_BRANCH) & w_take)) & ~reset;
    assign bus.alu_control = (r_state == S_EXECUTE) ? w_funct_alu : r_alu_control;
    assign bus.state       = r_state;

endmodule
`default_nettype wire
